// File: rtl/movegen_pkg.sv
// Shared definitions for the move-generation scheduler and square units:
// state encoding, move-word layout and the invalid-move constant.
package movegen_pkg;

    localparam int SQ_W         = 6;
    localparam int SLOT_W       = 19;
    localparam int SLOTS        = 8;
    localparam int SLOT_IW      = $clog2(SLOTS);
    localparam int WORD_W       = SLOT_W * SLOTS;
    localparam int Q_W          = 160;
    localparam int FLAG_INVALID = 18;

    // Empty slot filler written by a square unit; only the invalid flag matters.
    localparam logic [SLOT_W-1:0] IMOV = 19'h40000;

    // Move word layout: flag 18:12, from 11:6, to 5:0.
    typedef struct packed {
        logic [6:0] flag;
        logic [5:0] from_sq;
        logic [5:0] to_sq;
    } move_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_WAIT,
        S_SCAN,
        S_READ,
        S_LAT,
        S_EMIT,
        S_FIN
    } state_t;

endpackage

// File: rtl/movegen_scheduler_unpacker.sv
// Holds one captured FIFO word and walks its slots 7..0, skipping invalid
// moves in one cycle and holding valid ones until the consumer accepts.
module move_unpacker
    import movegen_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              active,
    input  logic [WORD_W-1:0] word_in,
    input  logic              mv_ready,
    output logic [SLOT_W-1:0] mv_data,
    output logic              mv_valid,
    output logic              accept,
    output logic              word_done
);

    logic [SLOTS-1:0][SLOT_W-1:0] word_q;
    logic [SLOT_IW-1:0]           idx;
    move_t                        cur;
    logic                         adv;

    assign cur       = word_q[idx];
    assign mv_data   = cur;
    assign mv_valid  = active & ~cur[FLAG_INVALID];
    assign accept    = mv_valid & mv_ready;
    // An invalid slot advances unconditionally; a valid one waits for ready.
    assign adv       = active & (cur[FLAG_INVALID] | mv_ready);
    assign word_done = adv & (idx == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q <= '0;
            idx    <= '0;
        end else if (load) begin
            word_q <= word_in;
            idx    <= SLOT_IW'(SLOTS - 1);
        end else if (adv && idx != '0) begin
            idx <= idx - 1'b1;
        end
    end

endmodule

// File: rtl/movegen_scheduler.sv
// One move-generation pass: clear the square units, wait for done, then drain
// every unit's FIFO in square order and stream the valid moves to the search.
module movegen_scheduler
    import movegen_pkg::*;
#(
    parameter int N_SQ       = 64,
    parameter int CLR_CYCLES = 2,
    parameter int TIMEOUT    = 255,
    parameter int CNT_W      = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              gen_done,
    output logic [CNT_W-1:0]  move_count,
    output logic              timeout_err,
    output logic              sq_reset,
    input  logic [N_SQ-1:0]   sq_done,
    input  logic [N_SQ-1:0]   sq_empty,
    output logic [N_SQ-1:0]   sq_rden,
    output logic [SQ_W-1:0]   sq_sel,
    input  logic [Q_W-1:0]    sq_q,
    output logic [SLOT_W-1:0] mv_data,
    output logic              mv_valid,
    input  logic              mv_ready
);

    localparam int CYC_W = $clog2(TIMEOUT + 1) + 1;

    state_t            state, state_nxt;
    logic [CYC_W-1:0]  cyc, cyc_nxt;
    logic [SQ_W-1:0]   sel_nxt;
    logic              terr_nxt;
    logic              start_acc;
    logic              done_q;
    logic              accept;
    logic              word_done;
    logic              unused_hi;

    assign unused_hi = ^sq_q[Q_W-1:WORD_W];

    always_comb begin
        state_nxt = state;
        cyc_nxt   = cyc;
        sel_nxt   = sq_sel;
        terr_nxt  = timeout_err;
        start_acc = 1'b0;
        case (state)
            S_IDLE: begin
                cyc_nxt = '0;
                if (start) begin
                    state_nxt = S_CLR;
                    terr_nxt  = 1'b0;
                    start_acc = 1'b1;
                end
            end
            S_CLR: begin
                if (cyc == CYC_W'(CLR_CYCLES - 1)) begin
                    state_nxt = S_WAIT;
                    cyc_nxt   = '0;
                end else begin
                    cyc_nxt = cyc + 1'b1;
                end
            end
            S_WAIT: begin
                cyc_nxt = cyc + 1'b1;
                // Timeout wins over a done arriving on the same edge.
                if (cyc_nxt == CYC_W'(TIMEOUT)) begin
                    terr_nxt  = 1'b1;
                    state_nxt = S_SCAN;
                    sel_nxt   = '0;
                end else if (done_q) begin
                    state_nxt = S_SCAN;
                    sel_nxt   = '0;
                end
            end
            S_SCAN: begin
                if (!sq_empty[sq_sel])
                    state_nxt = S_READ;
                else if (sq_sel == SQ_W'(N_SQ - 1))
                    state_nxt = S_FIN;
                else
                    sel_nxt = sq_sel + 1'b1;
            end
            S_READ:  state_nxt = S_LAT;
            S_LAT:   state_nxt = S_EMIT;
            // Back to SCAN on the same unit: it may hold further words.
            S_EMIT:  if (word_done) state_nxt = S_SCAN;
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            cyc         <= '0;
            sq_sel      <= '0;
            timeout_err <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state       <= state_nxt;
            cyc         <= cyc_nxt;
            sq_sel      <= sel_nxt;
            timeout_err <= terr_nxt;
            done_q      <= &sq_done;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            move_count <= '0;
        else if (start_acc)
            move_count <= '0;
        else if (accept && move_count != '1)
            move_count <= move_count + 1'b1;
    end

    // Outputs decode straight from state so an async reset drops them at once.
    assign busy     = (state != S_IDLE);
    assign gen_done = (state == S_FIN);
    assign sq_reset = (state == S_CLR);
    assign sq_rden  = (state == S_READ) ? (N_SQ'(1) << sq_sel) : '0;

    move_unpacker u_unpack (
        .clk       (clk),
        .reset     (reset),
        .load      (state == S_LAT),
        .active    (state == S_EMIT),
        .word_in   (sq_q[WORD_W-1:0]),
        .mv_ready  (mv_ready),
        .mv_data   (mv_data),
        .mv_valid  (mv_valid),
        .accept    (accept),
        .word_done (word_done)
    );

endmodule
